// File: rtl/tag_array_nway_if.sv
// Bus bundle between the cache controller (master) and the N-way tag store (slave).
// TAG_PARITY_EN adds the parity_err response flag.
interface tag_array_nway_if #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 6,
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = 2
);
  logic                lk_valid;
  logic                lk_ready;
  logic [TAG_W-1:0]    lk_tag;
  logic [INDEX_W-1:0]  lk_index;
  logic                rsp_valid;
  logic                rsp_hit;
  logic [WAY_W-1:0]    rsp_way;
  logic [NUM_WAYS-1:0] rsp_hit_vec;
  logic                rsp_multi;
  logic                fill_en;
  logic [WAY_W-1:0]    fill_way;
  logic [INDEX_W-1:0]  fill_index;
  logic [TAG_W-1:0]    fill_tag;
  logic                inv_en;
  logic [WAY_W-1:0]    inv_way;
  logic                flush_req;
  logic                flush_busy;
  logic                flush_done;
`ifdef TAG_PARITY_EN
  logic                parity_err;
`endif

  modport master (
    output lk_valid, lk_tag, lk_index, fill_en, fill_way, fill_index, fill_tag,
           inv_en, inv_way, flush_req,
    input  lk_ready, rsp_valid, rsp_hit, rsp_way, rsp_hit_vec, rsp_multi,
           flush_busy, flush_done
`ifdef TAG_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  lk_valid, lk_tag, lk_index, fill_en, fill_way, fill_index, fill_tag,
           inv_en, inv_way, flush_req,
    output lk_ready, rsp_valid, rsp_hit, rsp_way, rsp_hit_vec, rsp_multi,
           flush_busy, flush_done
`ifdef TAG_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/tag_array_nway.sv
// N-way set-associative tag store: registered lookup, tree pseudo-LRU victim, sequential flush.
// Optional TAG_PARITY_EN: per-tag even parity; a parity-bad match is a miss and invalidates the way.
module tag_array_nway #(
  parameter int TAG_W    = 20,
  parameter int NUM_SETS = 64,
  parameter int INDEX_W  = 6,
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = 2
) (
  input logic             clk,
  input logic             reset,
  tag_array_nway_if.slave bus
);
  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  logic [TAG_W-1:0]    r_tag   [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [NUM_WAYS-2:0] r_plru  [NUM_SETS];
  state_t              r_state, w_state_nxt;
  logic [INDEX_W-1:0]  r_cnt;
  logic                r_flush_done;
  logic                r_rsp_valid, r_rsp_hit, r_rsp_multi;
  logic [WAY_W-1:0]    r_rsp_way;
  logic [NUM_WAYS-1:0] r_rsp_hit_vec;

  logic                w_lk_acc, w_hit, w_has_inv, w_multi, w_last;
  logic [NUM_WAYS-1:0] w_tag_eq, w_match;
  logic [WAY_W-1:0]    w_hit_way, w_inv_way, w_rsp_way;
  logic [WAY_W:0]      w_cnt;

  // Tree walk from the root: bit=0 steers left, leaf order gives the way number.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    logic [WAY_W-1:0] way;
    logic             b;
    int               node;
    way  = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < NUM_WAYS-1; n++) if (n == node) b = bits[n];
      way[WAY_W-1-l] = b;
      node = 2*node + 1 + (b ? 1 : 0);
    end
    return way;
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_update(input logic [NUM_WAYS-2:0] bits,
                                                      input logic [WAY_W-1:0]    way);
    logic [NUM_WAYS-2:0] nb;
    logic                d;
    int                  node;
    nb   = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      d = way[WAY_W-1-l];
      for (int n = 0; n < NUM_WAYS-1; n++) if (n == node) nb[n] = ~d;
      node = 2*node + 1 + (d ? 1 : 0);
    end
    return nb;
  endfunction

`ifdef TAG_PARITY_EN
  logic                r_par [NUM_WAYS][NUM_SETS];
  logic                r_parity_err;
  logic [NUM_WAYS-1:0] w_par_bad;
  assign bus.parity_err = r_parity_err;
`endif

  assign w_lk_acc = bus.lk_valid && (r_state == ST_IDLE);
  assign w_last   = (r_cnt == INDEX_W'(NUM_SETS-1));

  always_comb begin
    w_tag_eq  = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    w_has_inv = 1'b0;
    w_cnt     = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      w_tag_eq[w] = r_valid[bus.lk_index][w] && (r_tag[w][bus.lk_index] == bus.lk_tag);
`ifdef TAG_PARITY_EN
    w_par_bad = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      w_par_bad[w] = w_tag_eq[w] && (r_par[w][bus.lk_index] != ^bus.lk_tag);
    w_match = w_tag_eq & ~w_par_bad;
`else
    w_match = w_tag_eq;
`endif
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (w_match[w]) w_hit_way = WAY_W'(w);
      if (!r_valid[bus.lk_index][w]) begin
        w_inv_way = WAY_W'(w);
        w_has_inv = 1'b1;
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) w_cnt = w_cnt + {{WAY_W{1'b0}}, w_match[w]};
    w_hit     = |w_match;
    w_multi   = (w_cnt > (WAY_W+1)'(1));
    w_rsp_way = w_hit ? w_hit_way : (w_has_inv ? w_inv_way : plru_victim(r_plru[bus.lk_index]));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.flush_req) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Control state: valid/pLRU arrays, flush counter, response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
      r_cnt         <= '0;
      r_flush_done  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_hit     <= 1'b0;
      r_rsp_way     <= '0;
      r_rsp_hit_vec <= '0;
      r_rsp_multi   <= 1'b0;
`ifdef TAG_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_rsp_valid  <= w_lk_acc;
      r_flush_done <= (r_state == ST_FLUSH) && w_last;
`ifdef TAG_PARITY_EN
      r_parity_err <= w_lk_acc && (|w_par_bad);
`endif
      if (w_lk_acc) begin
        r_rsp_hit     <= w_hit;
        r_rsp_way     <= w_rsp_way;
        r_rsp_hit_vec <= w_match;
        r_rsp_multi   <= w_multi;
      end
      if (r_state == ST_FLUSH) begin
        r_valid[r_cnt] <= '0;
        r_plru[r_cnt]  <= '0;
        r_cnt          <= r_cnt + INDEX_W'(1);
      end else begin
        // Later writes override earlier ones: fill beats invalidate and lookup-hit pLRU update.
`ifdef TAG_PARITY_EN
        if (w_lk_acc) r_valid[bus.lk_index] <= r_valid[bus.lk_index] & ~w_par_bad;
`endif
        if (w_lk_acc && w_hit) r_plru[bus.lk_index] <= plru_update(r_plru[bus.lk_index], w_hit_way);
        if (bus.inv_en) r_valid[bus.fill_index][bus.inv_way] <= 1'b0;
        if (bus.fill_en) begin
          r_valid[bus.fill_index][bus.fill_way] <= 1'b1;
          r_plru[bus.fill_index] <= plru_update(r_plru[bus.fill_index], bus.fill_way);
        end
      end
    end
  end

  // Tag (and parity) storage carries no reset.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && bus.fill_en) begin
      r_tag[bus.fill_way][bus.fill_index] <= bus.fill_tag;
`ifdef TAG_PARITY_EN
      r_par[bus.fill_way][bus.fill_index] <= ^bus.fill_tag;
`endif
    end
  end

  assign bus.lk_ready    = (r_state == ST_IDLE);
  assign bus.flush_busy  = (r_state == ST_FLUSH);
  assign bus.flush_done  = r_flush_done;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_hit     = r_rsp_hit;
  assign bus.rsp_way     = r_rsp_way;
  assign bus.rsp_hit_vec = r_rsp_hit_vec;
  assign bus.rsp_multi   = r_rsp_multi;
endmodule

// File: tb/tb_tag_array_nway.sv
// Directed bench for tag_array_nway (4 ways, 64 sets); parity steps compile only with TAG_PARITY_EN.
module tb_tag_array_nway;
  localparam int TAG_W = 20, NUM_SETS = 64, INDEX_W = 6, NUM_WAYS = 4, WAY_W = 2;

  logic clk;
  logic reset;
  int   n_pass, n_total;
  int   busy_cnt, done_cnt, rv_cnt;

  tag_array_nway_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) bus ();

  tag_array_nway #(.TAG_W(TAG_W), .NUM_SETS(NUM_SETS), .INDEX_W(INDEX_W),
                   .NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag);
    bus.lk_valid = 1'b1;
    bus.lk_index = idx;
    bus.lk_tag   = tag;
    tick();
    bus.lk_valid = 1'b0;
  endtask

  task automatic fill(input logic [INDEX_W-1:0] idx, input logic [WAY_W-1:0] way,
                      input logic [TAG_W-1:0] tag);
    bus.fill_en    = 1'b1;
    bus.fill_index = idx;
    bus.fill_way   = way;
    bus.fill_tag   = tag;
    tick();
    bus.fill_en = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic hit, input logic [WAY_W-1:0] way,
                            input logic [NUM_WAYS-1:0] vec, input logic multi);
    check({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".hit"},   32'(bus.rsp_hit), 32'(hit));
    check({tag, ".way"},   32'(bus.rsp_way), 32'(way));
    check({tag, ".vec"},   32'(bus.rsp_hit_vec), 32'(vec));
    check({tag, ".multi"}, 32'(bus.rsp_multi), 32'(multi));
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0;
    bus.lk_valid = 1'b0; bus.lk_tag = '0; bus.lk_index = '0;
    bus.fill_en = 1'b0; bus.fill_way = '0; bus.fill_index = '0; bus.fill_tag = '0;
    bus.inv_en = 1'b0; bus.inv_way = '0; bus.flush_req = 1'b0;
    repeat (3) tick();
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.flush_busy", 32'(bus.flush_busy), 32'd0);
    check("rst.flush_done", 32'(bus.flush_done), 32'd0);
    reset = 1'b1;
    tick();
    check("rst.lk_ready", 32'(bus.lk_ready), 32'd1);
    check("rst.rsp_hit", 32'(bus.rsp_hit), 32'd0);

    lookup(6'd5, 20'h123);
    expect_rsp("cold_miss", 1'b0, 2'd0, 4'b0000, 1'b0);
    tick();
    check("pulse.rsp_valid", 32'(bus.rsp_valid), 32'd0);

    for (int w = 0; w < 4; w++) fill(6'd5, WAY_W'(w), TAG_W'(32'hA0 + w));
    lookup(6'd5, 20'hA2);
    expect_rsp("hit_a2", 1'b1, 2'd2, 4'b0100, 1'b0);
    tick();
    check("hold.valid", 32'(bus.rsp_valid), 32'd0);
    check("hold.way", 32'(bus.rsp_way), 32'd2);
    check("hold.hit", 32'(bus.rsp_hit), 32'd1);

    for (int w = 0; w < 4; w++) begin
      lookup(6'd5, TAG_W'(32'hA0 + w));
      check("seq_hit.way", 32'(bus.rsp_way), 32'(w));
    end
    lookup(6'd5, 20'h555);
    expect_rsp("plru_miss1", 1'b0, 2'd0, 4'b0000, 1'b0);
    lookup(6'd5, 20'hA0);
    check("hit0.hit", 32'(bus.rsp_hit), 32'd1);
    lookup(6'd5, 20'h555);
    expect_rsp("plru_miss2", 1'b0, 2'd2, 4'b0000, 1'b0);

    // Lookup and fill of the same set/way in one cycle: old contents answer.
    bus.fill_en = 1'b1; bus.fill_index = 6'd5; bus.fill_way = 2'd1; bus.fill_tag = 20'hB1;
    lookup(6'd5, 20'hA1);
    bus.fill_en = 1'b0;
    expect_rsp("same_cyc_old", 1'b1, 2'd1, 4'b0010, 1'b0);
    lookup(6'd5, 20'hB1);
    expect_rsp("same_cyc_new", 1'b1, 2'd1, 4'b0010, 1'b0);
    lookup(6'd5, 20'hA1);
    expect_rsp("old_gone", 1'b0, 2'd2, 4'b0000, 1'b0);

    bus.inv_en = 1'b1; bus.fill_index = 6'd5; bus.inv_way = 2'd3;
    tick();
    bus.inv_en = 1'b0;
    lookup(6'd5, 20'hA3);
    expect_rsp("inv_miss", 1'b0, 2'd3, 4'b0000, 1'b0);
    bus.inv_en = 1'b1; bus.inv_way = 2'd3;
    fill(6'd5, 2'd3, 20'hC3);
    bus.inv_en = 1'b0;
    lookup(6'd5, 20'hC3);
    expect_rsp("fill_beats_inv", 1'b1, 2'd3, 4'b1000, 1'b0);
    fill(6'd5, 2'd0, 20'hB1);
    lookup(6'd5, 20'hB1);
    expect_rsp("dup_multi", 1'b1, 2'd0, 4'b0011, 1'b1);
    lookup(6'd6, 20'hA0);
    expect_rsp("other_set", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Flush entered with a lookup in the same cycle.
    bus.flush_req = 1'b1;
    lookup(6'd5, 20'hC3);
    bus.flush_req = 1'b0;
    expect_rsp("inflight", 1'b1, 2'd3, 4'b1000, 1'b0);
    check("flush.lk_ready", 32'(bus.lk_ready), 32'd0);
    busy_cnt = int'(bus.flush_busy);
    done_cnt = int'(bus.flush_done);
    rv_cnt   = 0;
    bus.lk_valid = 1'b1; bus.lk_index = 6'd0; bus.lk_tag = 20'h77;
    bus.fill_en = 1'b1; bus.fill_index = 6'd0; bus.fill_way = 2'd0; bus.fill_tag = 20'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      rv_cnt   += int'(bus.rsp_valid);
      busy_cnt += int'(bus.flush_busy);
      done_cnt += int'(bus.flush_done);
    end
    bus.lk_valid = 1'b0; bus.fill_en = 1'b0;
    check("flush.no_rsp", 32'(rv_cnt), 32'd0);
    for (int i = 0; i < 95; i++) begin
      tick();
      busy_cnt += int'(bus.flush_busy);
      done_cnt += int'(bus.flush_done);
    end
    check("flush.busy_cycles", 32'(busy_cnt), 32'd64);
    check("flush.done_pulses", 32'(done_cnt), 32'd1);
    check("flush.lk_ready_after", 32'(bus.lk_ready), 32'd1);
    lookup(6'd5, 20'hC3);
    expect_rsp("post_flush", 1'b0, 2'd0, 4'b0000, 1'b0);
    lookup(6'd0, 20'h77);
    expect_rsp("fill_ignored", 1'b0, 2'd0, 4'b0000, 1'b0);

    fill(6'd9, 2'd2, 20'h99);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    repeat (10) tick();
    check("abort.busy_before", 32'(bus.flush_busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort.busy_async", 32'(bus.flush_busy), 32'd0);
    check("abort.lk_ready", 32'(bus.lk_ready), 32'd1);
    tick();
    reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      done_cnt += int'(bus.flush_done);
    end
    check("abort.no_done", 32'(done_cnt), 32'd0);
    lookup(6'd9, 20'h99);
    expect_rsp("abort.invalid", 1'b0, 2'd0, 4'b0000, 1'b0);

`ifdef TAG_PARITY_EN
    fill(6'd9, 2'd0, 20'h5A);
    dut.r_par[0][9] = ~dut.r_par[0][9];
    lookup(6'd9, 20'h5A);
    expect_rsp("par_bad", 1'b0, 2'd1, 4'b0000, 1'b0);
    check("par_bad.err", 32'(bus.parity_err), 32'd1);
    lookup(6'd9, 20'h5A);
    expect_rsp("par_cleared", 1'b0, 2'd0, 4'b0000, 1'b0);
    check("par_cleared.err", 32'(bus.parity_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
